// File: rtl/rcas_multicycle.sv
// rcas_multicycle
// ---------------------------------------------------------------------------
// Multi-cycle ripple-carry adder/subtractor. A WIDTH-bit operation is
// processed SLICE bits per clock through one shared SLICE-bit adder. The
// carry between slices is held in a register. Signed-overflow and zero flags
// are produced alongside the result.
//
// Parameters
//   WIDTH     operand/result width; must be a multiple of SLICE
//   SLICE     bits processed per cycle (1..WIDTH)
//
// Ports
//   clk        in   single clock, rising-edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operand beat present
//   in_ready   out  block can accept a beat (IDLE)
//   a, b       in   WIDTH-bit operands
//   sel        in   0 = add, 1 = subtract (b inverted)
//   c_in       in   carry into bit 0, used as-is
//   out_valid  out  result beat present (DONE)
//   out_ready  in   consumer accepts the result beat
//   result     out  WIDTH-bit sum/difference
//   c_out      out  carry out of bit WIDTH-1
//   overflow   out  two's-complement overflow
//   zero       out  result == 0
// ---------------------------------------------------------------------------
module rcas_multicycle #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0]    LAST_SLICE = CW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_out_q, c_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  int               shamt;
  logic [WIDTH-1:0] a_shift, b_shift;
  logic [SLICE-1:0] a_sl, b_sl;
  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] merged;

  // Shared slice datapath. acc_q is the working accumulator that is filled
  // slice by slice; the visible result register only changes when the last
  // slice lands, so outputs keep their last completed value while BUSY.
  always_comb begin
    shamt     = SLICE * int'(cnt_q);
    a_shift   = a_q >> shamt;
    b_shift   = b_q >> shamt;
    a_sl      = a_shift[SLICE-1:0];
    b_sl      = b_shift[SLICE-1:0];
    slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE+1)'(carry_q);
    merged    = (acc_q & ~(SLICE_MASK << shamt)) |
                (WIDTH'(slice_sum[SLICE-1:0]) << shamt);
  end

  // Next-state logic for the IDLE/BUSY/DONE sequencer and all registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    result_d   = result_q;
    c_out_d    = c_out_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sel}};
          carry_d = c_in;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d   = merged;
        carry_d = slice_sum[SLICE];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_SLICE) begin
          cnt_d      = '0;
          result_d   = merged;
          c_out_d    = slice_sum[SLICE];
          // b_q already holds the inverted operand when subtracting.
          overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                       (merged[WIDTH-1] != a_q[WIDTH-1]);
          zero_d     = (merged == '0);
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register bank; reset wins over any handshake and drops in-flight work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign c_out     = c_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_rcas_multicycle.sv
// tb_rcas_multicycle
// ---------------------------------------------------------------------------
// Scoreboard bench for rcas_multicycle. Three instances are exercised one at
// a time: the default 32/4 build, a 32/32 build (single-cycle) and an 8/1
// build. The driver pushes hand-computed expected beats into a queue; the
// per-instance monitors pop and compare whenever out_valid is seen.
// ---------------------------------------------------------------------------
module tb_rcas_multicycle;

  typedef struct {
    int          dutId;
    logic [31:0] res;
    logic        co;
    logic        ov;
    logic        z;
    int          acceptCyc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  inValid;
  logic [2:0]  inReady;
  logic [2:0]  outValid;
  logic        outReady;
  logic [31:0] a, b;
  logic        sel, cIn;

  logic [31:0] result0, result1;
  logic [7:0]  result2;
  logic [2:0]  cOut, ovf, zro;

  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t expQ[$];
  bit   seen[3];
  bit   curOk[3];
  exp_t cur[3];
  int   latTab[3];

  // Free-running clock and edge counter used for latency checks.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Default build: WIDTH=32, SLICE=4.
  rcas_multicycle #(.WIDTH(32), .SLICE(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .a(a), .b(b), .sel(sel), .c_in(cIn), .out_valid(outValid[0]),
    .out_ready(outReady), .result(result0), .c_out(cOut[0]),
    .overflow(ovf[0]), .zero(zro[0])
  );

  // Single-slice build: whole word in one cycle.
  rcas_multicycle #(.WIDTH(32), .SLICE(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .a(a), .b(b), .sel(sel), .c_in(cIn), .out_valid(outValid[1]),
    .out_ready(outReady), .result(result1), .c_out(cOut[1]),
    .overflow(ovf[1]), .zero(zro[1])
  );

  // Narrow bit-serial build: WIDTH=8, SLICE=1.
  rcas_multicycle #(.WIDTH(8), .SLICE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .a(a[7:0]), .b(b[7:0]), .sel(sel), .c_in(cIn), .out_valid(outValid[2]),
    .out_ready(outReady), .result(result2), .c_out(cOut[2]),
    .overflow(ovf[2]), .zero(zro[2])
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor step for one instance: pop on the first cycle of a beat, then
  // keep checking that the held beat stays stable while back-pressured.
  task automatic scoreBeat(input int id, input logic v, input logic rdy,
                           input logic [31:0] res, input logic co,
                           input logic ov, input logic z);
    exp_t e;
    if (v !== 1'b1) begin
      seen[id] = 0;
    end else if (!seen[id]) begin
      seen[id] = 1;
      if (expQ.size() == 0) begin
        curOk[id] = 0;
        checkOutput("spurious_out_valid", 32'(id), 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        cur[id]   = e;
        curOk[id] = 1;
        checkOutput("dut_id", 32'(id), 32'(e.dutId));
        checkOutput("result", res, e.res);
        checkOutput("c_out", 32'(co), 32'(e.co));
        checkOutput("overflow", 32'(ov), 32'(e.ov));
        checkOutput("zero", 32'(z), 32'(e.z));
        checkOutput("latency", 32'(cyc - e.acceptCyc), 32'(e.lat));
        checkOutput("in_ready_in_done", 32'(rdy), 32'd0);
      end
    end else if (curOk[id]) begin
      checkOutput("hold_result", res, cur[id].res);
      checkOutput("hold_flags", {29'd0, co, ov, z},
                  {29'd0, cur[id].co, cur[id].ov, cur[id].z});
      checkOutput("hold_in_ready", 32'(rdy), 32'd0);
    end
  endtask

  // Monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) scoreBeat(0, outValid[0], inReady[0], result0,
                                  cOut[0], ovf[0], zro[0]);
  always @(negedge clk) scoreBeat(1, outValid[1], inReady[1], result1,
                                  cOut[1], ovf[1], zro[1]);
  always @(negedge clk) scoreBeat(2, outValid[2], inReady[2], {24'd0, result2},
                                  cOut[2], ovf[2], zro[2]);

  // Drive one operand beat into instance id and optionally queue its
  // expected response, stamped with the accept edge.
  task automatic applyStimulus(input int id, input logic [31:0] aa,
                               input logic [31:0] bb, input logic s,
                               input logic ci, input bit push,
                               input logic [31:0] er, input logic eco,
                               input logic eov, input logic ez);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    a = aa; b = bb; sel = s; cIn = ci;
    while (inReady[id] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (inReady[id] !== 1'b1) begin
      checkOutput("in_ready_timeout", 32'(inReady[id]), 32'd1);
      return;
    end
    inValid[id] = 1'b1;
    @(posedge clk);
    #1;
    inValid[id] = 1'b0;
    if (push) begin
      e.dutId = id; e.res = er; e.co = eco; e.ov = eov; e.z = ez;
      e.acceptCyc = cyc; e.lat = latTab[id];
      expQ.push_back(e);
    end
  endtask

  // Bounded wait for the scoreboard to empty.
  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
  endtask

  // Global safety net in case a task wait hangs unexpectedly.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    int n;
    latTab[0] = 8; latTab[1] = 1; latTab[2] = 8;
    rst_n = 1'b0; inValid = '0; outReady = 1'b1;
    a = '0; b = '0; sel = 1'b0; cIn = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset_in_ready", 32'(inReady[0]), 32'd1);
    checkOutput("reset_out_valid", 32'(outValid[0]), 32'd0);
    checkOutput("reset_result", result0, 32'd0);
    checkOutput("reset_flags", {29'd0, cOut[0], ovf[0], zro[0]}, 32'd0);
    rst_n = 1'b1;

    // Basic add, equal subtract, borrow, full carry chain, overflow cases.
    applyStimulus(0, 32'h5, 32'h3, 0, 0, 1, 32'h8, 0, 0, 0);                    waitDrain();
    applyStimulus(0, 32'h5, 32'h5, 1, 1, 1, 32'h0, 1, 0, 1);                    waitDrain();
    applyStimulus(0, 32'h3, 32'h5, 1, 1, 1, 32'hFFFF_FFFE, 0, 0, 0);            waitDrain();
    applyStimulus(0, 32'hFFFF_FFFF, 32'h1, 0, 0, 1, 32'h0, 1, 0, 1);            waitDrain();
    applyStimulus(0, 32'h7FFF_FFFF, 32'h1, 0, 0, 1, 32'h8000_0000, 0, 1, 0);    waitDrain();
    applyStimulus(0, 32'h8000_0000, 32'h1, 1, 1, 1, 32'h7FFF_FFFF, 1, 1, 0);    waitDrain();
    applyStimulus(0, 32'h1, 32'h1, 0, 1, 1, 32'h3, 0, 0, 0);                    waitDrain();

    // Back-pressure: hold out_ready low for 5 cycles after out_valid rises.
    outReady = 1'b0;
    applyStimulus(0, 32'h1234_5678, 32'h1111_1111, 0, 0, 1, 32'h2345_6789, 0, 0, 0);
    n = 0;
    while (outValid[0] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    outReady = 1'b1;
    waitDrain();

    // Input churn while BUSY must not disturb the latched operands.
    applyStimulus(0, 32'h0000_FFFF, 32'h1, 0, 0, 1, 32'h0001_0000, 0, 0, 0);
    repeat (5) begin
      @(negedge clk);
      a = $urandom; b = $urandom; sel = ~sel; inValid[0] = ~inValid[0];
    end
    @(negedge clk);
    inValid[0] = 1'b0;
    waitDrain();

    // Reset after four slices; the operation must vanish.
    applyStimulus(0, 32'hAAAA_AAAA, 32'h1111_1111, 0, 0, 0, 32'h0, 0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midbusy_reset_in_ready", 32'(inReady[0]), 32'd1);
    checkOutput("midbusy_reset_out_valid", 32'(outValid[0]), 32'd0);
    checkOutput("midbusy_reset_result", result0, 32'd0);
    applyStimulus(0, 32'h2, 32'h2, 0, 0, 1, 32'h4, 0, 0, 0);                    waitDrain();

    // Parameter corners.
    applyStimulus(1, 32'h10, 32'h20, 0, 0, 1, 32'h30, 0, 0, 0);                 waitDrain();
    applyStimulus(1, 32'h8000_0000, 32'h8000_0000, 0, 0, 1, 32'h0, 1, 1, 1);    waitDrain();
    applyStimulus(2, 32'h80, 32'h80, 0, 0, 1, 32'h00, 1, 1, 1);                 waitDrain();
    applyStimulus(2, 32'h05, 32'h07, 1, 1, 1, 32'hFE, 0, 0, 0);                 waitDrain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rcas_multicycle.md
# rcas_multicycle

Parametrised, multi-cycle ripple-carry adder/subtractor that processes a WIDTH-bit operation in SLICE-bit chunks, one chunk per clock, reusing a single SLICE-bit ripple-carry add/sub datapath and a registered inter-slice carry. It is the sequential, width-generic successor to the fixed 4-bit combinational add/sub cell. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It adds signed-overflow and zero flags.

## Interface

- WIDTH, 32, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; 1 ≤ SLICE ≤ WIDTH. NSLICE = WIDTH/SLICE.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sel  in  1  0 = add, 1 = subtract (B bitwise inverted).
- c_in  in  1  carry into bit 0, used as-is; subtract callers drive 1 for A−B.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result beat.
- result  out  WIDTH  sum/difference.
- c_out  out  1  carry out of bit WIDTH−1.
- overflow  out  1  two's-complement overflow.
- zero  out  1  result == 0.

## Operation

- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready:
  - latch a, b^{WIDTH{sel}}, and c_in into the carry register.
  - Clear the slice counter and go to BUSY.
- BUSY: in_ready=0, out_valid=0. Each cycle:
  - Slice k=counter adds A[k*SLICE +: SLICE] + Beff[k*SLICE +: SLICE] + carry.
  - Write the sum into the result register slice k and the slice carry-out into the carry register.
  - Increment the counter.
- On the edge completing slice NSLICE−1:
  - Update c_out, overflow, zero and go to DONE.
- DONE: out_valid=1, in_ready=0. result, c_out, overflow and zero are held stable. On out_ready, go to IDLE.
- Latched operands are immune to input changes after acceptance. in_valid is ignored outside IDLE.
- overflow = (A[W−1] == Beff[W−1]) && (result[W−1] != A[W−1]), using the inverted B when sel=1.
- zero is evaluated on the full WIDTH-bit result.
- result, c_out, overflow and zero are meaningful only while out_valid=1. Outside DONE they hold their last completed values.
- Carry out of each slice chains to the next. No carry-lookahead between slices.

## Timing

- Reset (rst_n=0 at an edge) forces IDLE. It takes priority over any handshake, including mid-BUSY and mid-DONE; the in-flight operation is dropped.
- Output values after reset edge: in_ready=1, out_valid=0, result=0, c_out=0, overflow=0, zero=0. The slice counter and carry register are cleared.
- Latency: accept at edge T, then out_valid=1 from edge T+NSLICE.
  - Example: 8 cycles for WIDTH=32, SLICE=4. With SLICE=WIDTH, 1 cycle.
- DONE→IDLE on the edge where out_ready=1. in_ready=1 the following cycle.
- Minimum issue interval is NSLICE+2 cycles. There is no overlap of consecutive operations.
- out_valid, once high, stays high with stable data until out_ready is sampled high.

## Test plan

All cases use WIDTH=32, SLICE=4, out_ready=1 unless stated.

- Add: a=0x00000005, b=0x00000003, sel=0, c_in=0 → result=0x00000008, c_out=0, overflow=0, zero=0. out_valid rises exactly 8 cycles after the accept edge.
- Subtract, equal operands and borrow: a=5, b=5, sel=1, c_in=1 → result=0, c_out=1, zero=1, overflow=0. Then a=3, b=5, sel=1, c_in=1 → result=0xFFFFFFFE, c_out=0, zero=0.
- Carry chain across all slices: a=0xFFFFFFFF, b=0x00000001, add, c_in=0 → result=0, c_out=1, zero=1, overflow=0. Also a=0x7FFFFFFF, b=1 → result=0x80000000, overflow=1, c_out=0.
- Backpressure and ignored input:
  - Hold out_ready=0 for 5 cycles after out_valid rises → result/flags stable, in_ready=0 throughout.
  - Toggle a, b and in_valid during BUSY → result unaffected.
- Synchronous reset mid-BUSY: drop rst_n for one edge after slice 3 → next cycle in_ready=1, out_valid=0, result=0. A fresh operation (2+2) then yields result=4 after 8 cycles.
- Parameter corner: instantiate with SLICE=32 → out_valid one cycle after accept. Instantiate with WIDTH=8, SLICE=1 → 0x80+0x80 gives result=0x00, c_out=1, overflow=1 after 8 cycles.
